// File: rtl/sram_arbiter.sv
// Three-requester SRAM arbiter with a 3-cycle IDLE/STROBE/CAPTURE access.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of round-robin.
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              chipselect_n,
  output logic              write_n,
  output logic              read_n,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        ack_q, ack_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;

  logic              any_req;
  logic [1:0]        sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;

  assign any_req = |req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = 2'd2;
    unique case (1'b1)
      req[0]:  sel = 2'd0;
      req[1]:  sel = 2'd1;
      default: sel = 2'd2;
    endcase
  end
`else
  logic [1:0] last_q, last_d;

  // Search starts one past the last winner.
  always_comb begin
    sel = 2'd0;
    case (last_q)
      2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = sel;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) last_q <= 2'd2;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    sel_we   = we[0];
    sel_addr = addr0;
    sel_wd   = wdata0;
    case (sel)
      2'd1: begin
        sel_we   = we[1];
        sel_addr = addr1;
        sel_wd   = wdata1;
      end
      2'd2: begin
        sel_we   = we[2];
        sel_addr = addr2;
        sel_wd   = wdata2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    gnt_d   = 3'b000;
    ack_d   = 3'b000;
    cs_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wd_d    = sel_wd;
          gnt_d   = 3'b001 << sel;
          cs_n_d  = 1'b0;
          wr_n_d  = ~sel_we;
          rd_n_d  = sel_we;
          state_d = STROBE;
        end
      end
      STROBE: state_d = CAPTURE;
      CAPTURE: begin
        if (!we_q) rdata_d = readdata;
        ack_d   = 3'b001 << win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      gnt_q   <= 3'b000;
      ack_q   <= 3'b000;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != IDLE);
  assign chipselect_n = cs_n_q;
  assign write_n      = wr_n_q;
  assign read_n       = rd_n_q;
  assign address      = addr_q;
  assign writedata    = wd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, read, write, latching, arbitration, abort.
// Expected values are hand-derived; SRAM_ARB_FIXED_PRIO_EN switches grant order.
module tb_sram_arbiter;

  logic        CLOCK_50;
  logic        RST;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [19:0] addr0, addr1, addr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt, ack;
  logic [15:0] rdata;
  logic        busy, chipselect_n, write_n, read_n;
  logic [19:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  int n_vec;
  int n_err;

  wire [9:0] st = {gnt, ack, chipselect_n, write_n, read_n, busy};

  sram_arbiter #(.ADDR_W(20), .DATA_W(16)) dut (
    .CLOCK_50     (CLOCK_50),
    .RST          (RST),
    .req          (req),
    .we           (we),
    .addr0        (addr0),
    .addr1        (addr1),
    .addr2        (addr2),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .wdata2       (wdata2),
    .gnt          (gnt),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .chipselect_n (chipselect_n),
    .write_n      (write_n),
    .read_n       (read_n),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b000; we = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    readdata = '0;
    RST = 1'b1;
    #3;
    n_vec++;
    if (st !== 10'b000_000_1110) begin
      n_err++;
      $display("FAIL reset_status got=%b want=%b", st, 10'b000_000_1110);
    end
    n_vec++;
    if ({address, writedata, rdata} !== 52'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0", {address, writedata, rdata});
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (st !== 10'b000_000_1110) begin
        n_err++;
        $display("FAIL idle_hold[%0d] got=%b want=%b", i, st, 10'b000_000_1110);
      end
    end
  endtask

  task automatic test_single_read();
    req = 3'b010; we = 3'b000; addr1 = 20'h00010; readdata = 16'hBEEF;
    tick();
    n_vec++;
    if (st !== 10'b010_000_0101 || address !== 20'h00010) begin
      n_err++;
      $display("FAIL read_e0 got=%b/%h want=%b/%h", st, address, 10'b010_000_0101, 20'h00010);
    end
    tick();
    n_vec++;
    if (st !== 10'b000_000_1111) begin
      n_err++;
      $display("FAIL read_e1 got=%b want=%b", st, 10'b000_000_1111);
    end
    tick();
    n_vec++;
    if (st !== 10'b000_010_1110 || rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL read_e2 got=%b/%h want=%b/%h", st, rdata, 10'b000_010_1110, 16'hBEEF);
    end
    req = 3'b000;
    tick();
    n_vec++;
    if (st !== 10'b000_000_1110) begin
      n_err++;
      $display("FAIL read_e3 got=%b want=%b", st, 10'b000_000_1110);
    end
  endtask

  task automatic test_single_write();
    req = 3'b001; we = 3'b001; addr0 = 20'hFFFFF; wdata0 = 16'h1234;
    readdata = 16'h5555;
    tick();
    n_vec++;
    if (st !== 10'b001_000_0011 || address !== 20'hFFFFF || writedata !== 16'h1234) begin
      n_err++;
      $display("FAIL write_e0 got=%b/%h/%h want=%b/fffff/1234", st, address, writedata, 10'b001_000_0011);
    end
    tick();
    n_vec++;
    if (st !== 10'b000_000_1111) begin
      n_err++;
      $display("FAIL write_e1 got=%b want=%b", st, 10'b000_000_1111);
    end
    tick();
    n_vec++;
    if (st !== 10'b000_001_1110 || rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_e2 got=%b/%h want=%b/beef", st, rdata, 10'b000_001_1110);
    end
    req = 3'b000; we = 3'b000;
    tick();
  endtask

  task automatic test_addr_latch();
    req = 3'b010; we = 3'b000; addr1 = 20'h00020; readdata = 16'h0A0A;
    tick();
    n_vec++;
    if (address !== 20'h00020 || gnt !== 3'b010) begin
      n_err++;
      $display("FAIL latch_e0 got=%h/%b want=00020/010", address, gnt);
    end
    addr1 = 20'h00030;
    tick();
    n_vec++;
    if (address !== 20'h00020) begin
      n_err++;
      $display("FAIL latch_e1 got=%h want=00020", address);
    end
    tick();
    n_vec++;
    if (address !== 20'h00020 || ack !== 3'b010 || rdata !== 16'h0A0A) begin
      n_err++;
      $display("FAIL latch_e2 got=%h/%b/%h want=00020/010/0a0a", address, ack, rdata);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_arbitration();
    logic [2:0] order [4];
    logic [2:0] eg, ea;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001; order[3] = 3'b001;
`else
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
`endif
    do_reset();
    req = 3'b111; we = 3'b000; readdata = 16'h7777;
    for (int k = 0; k < 12; k++) begin
      tick();
      eg = (k % 3 == 0) ? order[k / 3] : 3'b000;
      ea = (k % 3 == 2) ? order[k / 3] : 3'b000;
      n_vec++;
      if (gnt !== eg || ack !== ea || busy !== (k % 3 != 2) || write_n !== 1'b1) begin
        n_err++;
        $display("FAIL arb[%0d] got gnt=%b ack=%b busy=%b wn=%b want gnt=%b ack=%b",
                 k, gnt, ack, busy, write_n, eg, ea);
      end
    end
    req = 3'b000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    req = 3'b001; we = 3'b000;
    tick();
    n_vec++;
    if (gnt !== 3'b001 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_e0 got=%b/%b want=001/1", gnt, busy);
    end
    tick();
    RST = 1'b1;
    #1;
    n_vec++;
    if (st !== 10'b000_000_1110) begin
      n_err++;
      $display("FAIL abort_async got=%b want=%b", st, 10'b000_000_1110);
    end
    req = 3'b101;
    tick();
    n_vec++;
    if (st !== 10'b000_000_1110) begin
      n_err++;
      $display("FAIL abort_noack got=%b want=%b", st, 10'b000_000_1110);
    end
    RST = 1'b0;
    tick();
    n_vec++;
    if (gnt !== 3'b001) begin
      n_err++;
      $display("FAIL abort_regrant got=%b want=001", gnt);
    end
    tick();
    tick();
    req = 3'b100;
    tick();
    n_vec++;
    if (gnt !== 3'b100) begin
      n_err++;
      $display("FAIL abort_next got=%b want=100", gnt);
    end
    req = 3'b000;
    tick();
    tick();
    req = 3'b100;
    do_reset();
    tick();
    n_vec++;
    if (gnt !== 3'b100 || read_n !== 1'b0) begin
      n_err++;
      $display("FAIL abort_only2 got=%b/%b want=100/0", gnt, read_n);
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_addr_latch();
    test_arbitration();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
